// File: rtl/motion_control_if.sv
// motion_control_if -- groups the frame strobe, button levels, position
// feedback and motion outputs of the motion controller.
//   tick        : one-cycle frame strobe
//   btn_left    : held-level left request
//   btn_right   : held-level right request
//   btn_jump    : jump button level
//   Coordinate  : current position {x[31:16], y[15:0]}
//   Move_arrow  : {up, down, left, right}, valid the cycle after a tick
//   Move_speed  : {vertical[31:16], horizontal[15:0]}, same timing
//   State       : 0 = GROUND, 1 = RISING, 2 = FALLING
// The slave modport is the controller; the master modport is whoever drives it.
interface motion_control_if;
    logic        tick;
    logic        btn_left;
    logic        btn_right;
    logic        btn_jump;
    logic [31:0] Coordinate;
    logic [3:0]  Move_arrow;
    logic [31:0] Move_speed;
    logic [1:0]  State;

    modport slave (
        input  tick, btn_left, btn_right, btn_jump, Coordinate,
        output Move_arrow, Move_speed, State
    );

    modport master (
        output tick, btn_left, btn_right, btn_jump, Coordinate,
        input  Move_arrow, Move_speed, State
    );
endinterface

// File: rtl/motion_control.sv
// motion_control -- per-frame walk / jump / gravity controller.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : motion_control_if.slave (tick, buttons, Coordinate in;
//         Move_arrow, Move_speed, State out)
// All inputs are evaluated in the tick cycle; the motion outputs are
// registered, so they are nonzero only in the cycle after a tick and are
// applied by the downstream coordinate stage in that cycle.
module motion_control #(
    parameter logic [15:0] GROUND_Y = 16'd400,
    parameter logic [15:0] X_MIN    = 16'd16,
    parameter logic [15:0] X_MAX    = 16'd624,
    parameter logic [15:0] WALK     = 16'd4,
    parameter logic [15:0] JUMP_V0  = 16'd12,
    parameter logic [15:0] GRAVITY  = 16'd1,
    parameter logic [15:0] MAX_FALL = 16'd12
) (
    input  logic             clk,
    input  logic             rst,
    motion_control_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_GROUND  = 2'd0,
        ST_RISING  = 2'd1,
        ST_FALLING = 2'd2,
        ST_BAD     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] vy_q, vy_d;
    logic        jump_pending_q, jump_pending_d;
    logic        jump_prev_q;
    logic [3:0]  arrow_q, arrow_d;
    logic [31:0] speed_q, speed_d;

    logic [15:0] x_s, y_s;
    logic        jump_edge_s, jump_req_s;
    logic [15:0] left_room_s, right_room_s;
    logic [15:0] walk_left_s, walk_right_s;
    logic [16:0] vy_sum_s;
    logic [15:0] vn_s, drop_s, rise_s;

    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        min16 = (a < b) ? a : b;
    endfunction

    assign x_s = bus.Coordinate[31:16];
    assign y_s = bus.Coordinate[15:0];

    // An edge arriving in the tick cycle itself still counts for that tick.
    assign jump_edge_s = bus.btn_jump & ~jump_prev_q;
    assign jump_req_s  = jump_pending_q | jump_edge_s;

    // Distance to each wall, saturating at zero if already past it.
    assign left_room_s  = (x_s > X_MIN) ? (x_s - X_MIN) : 16'd0;
    assign right_room_s = (X_MAX > x_s) ? (X_MAX - x_s) : 16'd0;
    assign walk_left_s  = min16(WALK, left_room_s);
    assign walk_right_s = min16(WALK, right_room_s);

    // Next fall speed, computed one bit wider so the cap is applied before truncation.
    assign vy_sum_s = {1'b0, vy_q} + {1'b0, GRAVITY};
    assign vn_s     = (vy_sum_s > {1'b0, MAX_FALL}) ? MAX_FALL : vy_sum_s[15:0];
    assign drop_s   = GROUND_Y - y_s;
    assign rise_s   = min16(vy_q, y_s);

    // Next-state, vertical speed, jump latch and motion outputs for this cycle.
    always_comb begin
        state_d        = state_q;
        vy_d           = vy_q;
        arrow_d        = 4'b0000;
        speed_d        = 32'd0;
        jump_pending_d = jump_pending_q | jump_edge_s;

        if (bus.tick) begin
            // The latch is consumed by every tick, whether a jump happens or not.
            jump_pending_d = 1'b0;

            if (bus.btn_left && !bus.btn_right) begin
                speed_d[15:0] = walk_left_s;
                arrow_d[1]    = (walk_left_s != 16'd0);
            end else if (bus.btn_right && !bus.btn_left) begin
                speed_d[15:0] = walk_right_s;
                arrow_d[0]    = (walk_right_s != 16'd0);
            end else begin
                speed_d[15:0] = 16'd0;
            end

            case (state_q)
                ST_GROUND: begin
                    if (y_s < GROUND_Y) begin
                        state_d = ST_FALLING;
                        vy_d    = 16'd0;
                    end else if (jump_req_s) begin
                        state_d        = ST_RISING;
                        arrow_d[3]     = 1'b1;
                        speed_d[31:16] = JUMP_V0;
                        vy_d           = JUMP_V0 - GRAVITY;
                    end else begin
                        vy_d = vy_q;
                    end
                end
                ST_RISING: begin
                    arrow_d[3]     = 1'b1;
                    speed_d[31:16] = rise_s;
                    // vy >= y means this step reaches the ceiling at y = 0.
                    if ((vy_q <= GRAVITY) || (vy_q >= y_s)) begin
                        state_d = ST_FALLING;
                        vy_d    = 16'd0;
                    end else begin
                        vy_d = vy_q - GRAVITY;
                    end
                end
                ST_FALLING: begin
                    if (y_s >= GROUND_Y) begin
                        state_d = ST_GROUND;
                        vy_d    = 16'd0;
                    end else if (vn_s >= drop_s) begin
                        arrow_d[2]     = 1'b1;
                        speed_d[31:16] = drop_s;
                        state_d        = ST_GROUND;
                        vy_d           = 16'd0;
                    end else begin
                        arrow_d[2]     = 1'b1;
                        speed_d[31:16] = vn_s;
                        vy_d           = vn_s;
                    end
                end
                default: begin
                    state_d = ST_FALLING;
                    vy_d    = 16'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, speed, jump history and registered motion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_GROUND;
            vy_q           <= 16'd0;
            jump_pending_q <= 1'b0;
            jump_prev_q    <= 1'b0;
            arrow_q        <= 4'b0000;
            speed_q        <= 32'd0;
        end else begin
            state_q        <= state_d;
            vy_q           <= vy_d;
            jump_pending_q <= jump_pending_d;
            jump_prev_q    <= bus.btn_jump;
            arrow_q        <= arrow_d;
            speed_q        <= speed_d;
        end
    end

    assign bus.Move_arrow = arrow_q;
    assign bus.Move_speed = speed_q;
    assign bus.State      = state_q;

endmodule

// File: doc/motion_control.md
MOTION_CONTROL -- requirements
Module: motion_control

Interface
REQ-001 Parameters, one per line:
- GROUND_Y, 400, floor y.
- X_MIN, 16, left x limit.
- X_MAX, 624, right x limit.
- WALK, 4, horizontal step per tick.
- JUMP_V0, 12, initial rise speed.
- GRAVITY, 1, speed change per tick.
- MAX_FALL, 12, fall speed cap.

REQ-002 Ports, one per line:
- clk  in  1  clock.
- rst  in  1  reset.
- tick  in  1  one-cycle frame strobe.
- btn_left  in  1  held-level left request.
- btn_right  in  1  held-level right request.
- btn_jump  in  1  jump button, level.
- Coordinate  in  32  current position {x[31:16], y[15:0]}, fed back from the coordinate register stage.
- Move_arrow  out  4  {up, down, left, right}.
- Move_speed  out  32  {vertical[31:16], horizontal[15:0]}.
- State  out  2  0 = GROUND, 1 = RISING, 2 = FALLING.

REQ-003 One clock (clk); rst is synchronous, active-high.

Function
REQ-004 Move_arrow and Move_speed are registered and nonzero only in the single cycle following a tick cycle; they are zero in all other cycles.
- Reason: the downstream stage applies them every clk.
- Ticks are guaranteed at least 3 cycles apart.

REQ-005 Coordinate and all button state are evaluated in the tick cycle; results appear one cycle later (latency 1).

REQ-006 Jump edge detection:
- btn_jump rising edges are detected via an internal registered previous value.
- A detected edge sets jump_pending.
- jump_pending is cleared at every tick, whether used or not.
- An edge in the tick cycle itself counts for that tick.

REQ-007 Horizontal motion, per tick:
- left only: arrow[1]=1, speed min(WALK, x-X_MIN).
- right only: arrow[0]=1, speed min(WALK, X_MAX-x).
- both or neither: no motion.
- If the clamped speed is 0, the arrow bit is 0.

REQ-008 Internal vertical speed vy is 16 bits, unsigned; it never underflows.

REQ-009 GROUND at tick:
- If y < GROUND_Y: go to FALLING with vy=0; no vertical output; jump ignored.
- Else if jump_pending: go to RISING; output up with speed JUMP_V0; vy=JUMP_V0-GRAVITY.
- Else: no vertical output.

REQ-010 RISING at tick:
- Output up with speed min(vy, y), the ceiling clamp at y=0.
- If vy <= GRAVITY, or the ceiling is hit: go to FALLING, vy=0.
- Else: vy -= GRAVITY.

REQ-011 FALLING at tick:
- vn = min(vy+GRAVITY, MAX_FALL); d = GROUND_Y - y.
- If y >= GROUND_Y: go to GROUND with no vertical output.
- Else if vn >= d: output down with speed d; go to GROUND; vy=0.
- Else: output down with speed vn; vy=vn.

REQ-012 Horizontal and vertical motion are independent; both may be asserted in the same output cycle.

REQ-013 Non-tick cycles never change State or vy.

REQ-014 Undefined State encoding (3) recovers to FALLING at the next tick.

Reset
REQ-015 While rst=1 at a clk edge, the following are cleared on that edge:
- State=GROUND.
- vy=0.
- jump_pending=0.
- Move_arrow=0.
- Move_speed=0.
- Button history = 0.

REQ-016 Reset mid-jump abandons the jump with no further output; the next tick re-evaluates from GROUND per REQ-009.

Verification
REQ-017 Ground jump:
- Stimulus: y=400, btn_jump pulse, then ticks, with Coordinate integrated per output.
- Response: up speeds 12, 11, ..., 1 (apex y=322), then down speeds 1, 2, ..., 12; lands at y=400; State returns to GROUND.

REQ-018 Post-reset drop:
- Stimulus: Coordinate {320, 100}, no buttons.
- Response: first tick gives FALLING with no output; then down 1..12, then 12 repeated; final step 6; y=400; GROUND.

REQ-019 Edge clamp:
- Stimulus: x=18, btn_left held.
- Response: first tick arrow=4'b0010 with horizontal speed 2; next tick (x=16) arrow=0, speed 0.

REQ-020 Both directions and timing:
- Stimulus: btn_left=btn_right=1.
- Response: no horizontal motion.
- Also check outputs are zero in every cycle except tick+1.

REQ-021 Jump while airborne:
- Stimulus: jump pulse during RISING or FALLING.
- Response: ignored; pending cleared at the next tick; no re-jump after landing unless a new edge occurs.

REQ-022 Reset mid-rise:
- Stimulus: rst asserted while State=1.
- Response: next cycle State=0 and outputs 0.
